// File: rtl/timer_alarm_pkg.sv
// Shared definitions for the multi-channel alarm scheduler.
// Contents:
//   - register byte offsets (STATUS, channel block base and stride, and the
//     per-channel register offsets inside a block)
//   - CTRL bit positions
//   - ch_cfg_t: the complete software-visible configuration of one channel
package timer_alarm_pkg;

  localparam int unsigned STATUS    = 32'h00;
  localparam int unsigned CH_BASE   = 32'h10;
  localparam int unsigned CH_STRIDE = 32'h10;

  localparam int unsigned CTRL      = 32'h0;
  localparam int unsigned CMP_LO    = 32'h4;
  localparam int unsigned CMP_HI    = 32'h8;
  localparam int unsigned PERIOD    = 32'hC;

  localparam int unsigned EN        = 0;
  localparam int unsigned PERIODIC  = 1;
  localparam int unsigned IRQ_EN    = 2;

  typedef struct packed {
    logic        en;
    logic        periodic;
    logic        irq_en;
    logic [63:0] cmp;
    logic [31:0] period;
  } ch_cfg_t;

endpackage

// File: rtl/timer_alarm_ctrl_if.sv
// MMIO handshake between the bus master and the alarm block.
// Signals:
//   select     block select
//   mem_wstrb  write strobes (any nonzero strobe writes the whole word)
//   mem_addr   byte address
//   mem_wdata  write data
//   mem_rdata  read data, combinational, 0 when not selected
//   mem_ready  single-cycle response, mirrors select
interface timer_alarm_ctrl_if;

  logic        select;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output select, mem_wstrb, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  select, mem_wstrb, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/alarm_cmp_unit.sv
// The single comparator and reload adder shared by all alarm channels.
// Purely combinational; evaluates whichever channel the scan pointer selects.
// Ports:
//   cfg_i       configuration of the channel being visited
//   us_cnt_i    current microsecond count
//   fire_o      channel is enabled and the count has reached its compare value
//   next_cmp_o  compare value to store if the channel fires
//   next_en_o   enable to store if the channel fires (0 for one-shot or
//               a zero period, which would otherwise re-fire forever)
module alarm_cmp_unit
  import timer_alarm_pkg::*;
(
  input  ch_cfg_t     cfg_i,
  input  logic [63:0] us_cnt_i,
  output logic        fire_o,
  output logic [63:0] next_cmp_o,
  output logic        next_en_o
);

  logic reload;
  logic unused_irq_en;

  assign unused_irq_en = cfg_i.irq_en;

  always_comb begin
    reload     = cfg_i.periodic && (cfg_i.period != '0);
    fire_o     = cfg_i.en && (us_cnt_i >= cfg_i.cmp);
    // 64-bit add wraps modulo 2^64 by construction.
    next_cmp_o = reload ? (cfg_i.cmp + {32'd0, cfg_i.period}) : cfg_i.cmp;
    next_en_o  = reload;
  end

endmodule

// File: rtl/timer_alarm_ctrl.sv
// Multi-channel alarm scheduler on top of the free-running microsecond count.
// A round-robin pointer visits one channel per cycle and feeds it to the
// shared alarm_cmp_unit; firing sets a pending flag and either reloads the
// compare value (periodic) or disables the channel (one-shot).
// Ports:
//   clk_i     MCU clock (also clocks the us count source)
//   rst_i     synchronous active-high reset
//   bus       MMIO slave: STATUS (W1C pending) at 0x00, channel n registers
//             CTRL/CMP_LO/CMP_HI/PERIOD at 0x10 + n*0x10 + {0,4,8,C}
//   us_cnt_i  current microsecond count
//   irq_o     OR over channels of pending & irq_en
module timer_alarm_ctrl
  import timer_alarm_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  timer_alarm_ctrl_if.slave  bus,
  input  logic [63:0]        us_cnt_i,
  output logic               irq_o
);

  localparam int unsigned PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  ch_cfg_t           cfg_q [NUM_CH];
  ch_cfg_t           cfg_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [PW-1:0]     ptr_q, ptr_d;

  logic [31:0]       aw;
  logic              wr;
  logic              st_hit;
  logic [NUM_CH-1:0] hit_ctrl, hit_lo, hit_hi, hit_per;
  logic [NUM_CH-1:0] ch_wr;
  logic [NUM_CH-1:0] irq_en_vec;
  logic [31:0]       rd;
  logic              unused_addr;

  ch_cfg_t           cur;
  logic              fire;
  logic [63:0]       next_cmp;
  logic              next_en;

  // Only addr[7:2] is decoded; everything else aliases.
  assign aw          = {24'd0, bus.mem_addr[7:2], 2'b00};
  assign unused_addr = ^{bus.mem_addr[31:8], bus.mem_addr[1:0]};
  assign wr          = bus.select && (bus.mem_wstrb != '0);
  assign st_hit      = (aw == STATUS);

  always_comb begin
    hit_ctrl   = '0;
    hit_lo     = '0;
    hit_hi     = '0;
    hit_per    = '0;
    ch_wr      = '0;
    irq_en_vec = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      hit_ctrl[n]   = (aw == CH_BASE + n * CH_STRIDE + CTRL);
      hit_lo[n]     = (aw == CH_BASE + n * CH_STRIDE + CMP_LO);
      hit_hi[n]     = (aw == CH_BASE + n * CH_STRIDE + CMP_HI);
      hit_per[n]    = (aw == CH_BASE + n * CH_STRIDE + PERIOD);
      ch_wr[n]      = wr && (hit_ctrl[n] || hit_lo[n] || hit_hi[n] || hit_per[n]);
      irq_en_vec[n] = cfg_q[n].irq_en;
    end
  end

  assign cur = cfg_q[ptr_q];

  alarm_cmp_unit u_cmp (
    .cfg_i      (cur),
    .us_cnt_i   (us_cnt_i),
    .fire_o     (fire),
    .next_cmp_o (next_cmp),
    .next_en_o  (next_en)
  );

  always_comb begin
    cfg_d  = cfg_q;
    pend_d = pend_q;

    if (wr && st_hit) begin
      pend_d = pend_q & ~bus.mem_wdata[NUM_CH-1:0];
    end

    for (int unsigned n = 0; n < NUM_CH; n++) begin
      if (wr && hit_ctrl[n]) begin
        cfg_d[n].en       = bus.mem_wdata[EN];
        cfg_d[n].periodic = bus.mem_wdata[PERIODIC];
        cfg_d[n].irq_en   = bus.mem_wdata[IRQ_EN];
      end
      if (wr && hit_lo[n]) cfg_d[n].cmp[31:0]  = bus.mem_wdata;
      if (wr && hit_hi[n]) cfg_d[n].cmp[63:32] = bus.mem_wdata;
      if (wr && hit_per[n]) cfg_d[n].period    = bus.mem_wdata;
    end

    // Scanner update comes after the W1C so a coincident hardware set wins,
    // and is dropped when software writes the visited channel this cycle.
    if (fire && !ch_wr[ptr_q]) begin
      cfg_d[ptr_q].cmp = next_cmp;
      cfg_d[ptr_q].en  = next_en;
      pend_d[ptr_q]    = 1'b1;
    end

    ptr_d = (ptr_q == PW'(NUM_CH - 1)) ? '0 : ptr_q + PW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        cfg_q[n] <= '0;
      end
      pend_q <= '0;
      ptr_q  <= '0;
    end else begin
      cfg_q  <= cfg_d;
      pend_q <= pend_d;
      ptr_q  <= ptr_d;
    end
  end

  always_comb begin
    rd = '0;
    if (st_hit) rd = 32'(pend_q);
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      if (hit_ctrl[n]) rd = {29'd0, cfg_q[n].irq_en, cfg_q[n].periodic, cfg_q[n].en};
      if (hit_lo[n])   rd = cfg_q[n].cmp[31:0];
      if (hit_hi[n])   rd = cfg_q[n].cmp[63:32];
      if (hit_per[n])  rd = cfg_q[n].period;
    end
  end

  assign bus.mem_rdata = bus.select ? rd : '0;
  assign bus.mem_ready = bus.select;
  assign irq_o         = |(pend_q & irq_en_vec);

endmodule

// File: tb/tb_timer_alarm_ctrl.sv
// Self-checking bench for timer_alarm_ctrl: directed scenarios plus a random
// phase, all checked against a behavioural model of the register set kept
// in plain arrays (channel visited in cycle k is k mod NUM_CH).
module tb_timer_alarm_ctrl;

  localparam int unsigned NUM_CH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] us;
  logic        irq;

  timer_alarm_ctrl_if bus_if ();

  timer_alarm_ctrl #(.NUM_CH(NUM_CH)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .bus      (bus_if),
    .us_cnt_i (us),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model
  bit              m_en   [NUM_CH];
  bit              m_per  [NUM_CH];
  bit              m_ie   [NUM_CH];
  longint unsigned m_cmp  [NUM_CH];
  int unsigned     m_prd  [NUM_CH];
  int unsigned     m_pend;
  int unsigned     m_cyc;

  function automatic bit m_irq();
    for (int n = 0; n < NUM_CH; n++) if (m_pend[n] && m_ie[n]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input int unsigned a);
    int unsigned off, ch;
    logic [63:0] c;
    off = a & 32'hFC;
    if (off == 0) return m_pend;
    if (off >= 16 && off < 16 + 16 * NUM_CH) begin
      ch = (off - 16) / 16;
      c  = m_cmp[ch];
      case (off % 16)
        0:  return {29'd0, m_ie[ch], m_per[ch], m_en[ch]};
        4:  return c[31:0];
        8:  return c[63:32];
        default: return m_prd[ch];
      endcase
    end
    return 32'h0;
  endfunction

  // Advance the model by one clock using the inputs present now.
  task automatic model_edge();
    int unsigned p, off, ch;
    int          wch;
    bit          wr, fire;
    logic [31:0] d;
    logic [63:0] c;
    if (rst) begin
      for (int n = 0; n < NUM_CH; n++) begin
        m_en[n] = 0; m_per[n] = 0; m_ie[n] = 0; m_cmp[n] = 0; m_prd[n] = 0;
      end
      m_pend = 0;
      m_cyc  = 0;
      return;
    end
    p    = m_cyc % NUM_CH;
    fire = m_en[p] && (us >= m_cmp[p]);
    wch  = -1;
    wr   = bus_if.select && (bus_if.mem_wstrb != 4'h0);
    d    = bus_if.mem_wdata;
    off  = 32'(bus_if.mem_addr[7:0]) & 32'hFC;
    if (wr) begin
      if (off == 0) begin
        m_pend = m_pend & ~d & ((1 << NUM_CH) - 1);
      end else if (off >= 16 && off < 16 + 16 * NUM_CH) begin
        ch  = (off - 16) / 16;
        wch = int'(ch);
        c   = m_cmp[ch];
        case (off % 16)
          0: begin m_en[ch] = d[0]; m_per[ch] = d[1]; m_ie[ch] = d[2]; end
          4: m_cmp[ch] = {c[63:32], d};
          8: m_cmp[ch] = {d, c[31:0]};
          default: m_prd[ch] = d;
        endcase
      end
    end
    if (fire && wch != int'(p)) begin
      m_pend = m_pend | (1 << p);
      if (m_per[p] && m_prd[p] != 0) m_cmp[p] = m_cmp[p] + 64'(m_prd[p]);
      else m_en[p] = 0;
    end
    m_cyc++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus_if.select    = 1'b1;
    bus_if.mem_wstrb = 4'($urandom_range(1, 15));
    bus_if.mem_addr  = a;
    bus_if.mem_wdata = d;
    step();
    bus_if.select    = 1'b0;
    bus_if.mem_wstrb = 4'h0;
  endtask

  // Samples read data and the model's expectation at the same instant,
  // then spends one clock so the model stays aligned with the scan.
  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d,
                        output logic rdy, output logic [31:0] e);
    bus_if.select    = 1'b1;
    bus_if.mem_wstrb = 4'h0;
    bus_if.mem_addr  = a;
    #1;
    d   = bus_if.mem_rdata;
    rdy = bus_if.mem_ready;
    e   = m_read(a);
    step();
    bus_if.select = 1'b0;
  endtask

  task automatic align(input int unsigned p);
    for (int i = 0; i < NUM_CH && (m_cyc % NUM_CH) != p; i++) step();
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    logic        rdy;
    do_reset();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    checks++;
    if (bus_if.mem_ready !== 1'b0 || bus_if.mem_rdata !== 32'h0) begin
      errors++;
      $display("FAIL idle_bus: ready=%b rdata=%h want 0/0", bus_if.mem_ready, bus_if.mem_rdata);
    end
    for (int unsigned a = 0; a < 16 + 16 * NUM_CH; a += 4) begin
      bus_rd(a, d, rdy, e);
      checks++;
      if (d !== 32'h0 || rdy !== 1'b1) begin
        errors++;
        $display("FAIL reset_reg@%0h: got %h rdy=%b want 0 rdy=1", a, d, rdy);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] d, e;
    logic        rdy;
    int          n100, lat;
    do_reset();
    us = 0;
    bus_wr(32'h14, 100);
    bus_wr(32'h18, 0);
    bus_wr(32'h10, 32'h5);
    us = 90; n100 = 0; lat = 0;
    for (int i = 0; i < 20; i++) begin
      if (us >= 100) n100++;
      step();
      checks++;
      if (irq !== m_irq()) begin errors++; $display("FAIL oneshot_irq us=%0d: got %b want %b", us, irq, m_irq()); end
      if (irq === 1'b1 && lat == 0) lat = n100;
      us = us + 1;
    end
    checks++;
    if (lat < 1 || lat > NUM_CH) begin errors++; $display("FAIL oneshot_latency: got %0d want 1..%0d", lat, NUM_CH); end
    bus_rd(32'h10, d, rdy, e);
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL oneshot_ctrl0: got %h want 4", d); end
    bus_rd(32'h0, d, rdy, e);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL oneshot_status: got %h want 1", d); end
    bus_wr(32'h0, 32'h1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_w1c_irq: got %b want 0", irq); end
  endtask

  task automatic test_periodic();
    logic [31:0] d, e;
    logic        rdy;
    int          clears;
    do_reset();
    us = 0;
    bus_wr(32'h24, 50);
    bus_wr(32'h28, 0);
    bus_wr(32'h2C, 25);
    bus_wr(32'h20, 32'h3);
    clears = 0;
    us = 40;
    while (us <= 140) begin
      bus_rd(32'h0, d, rdy, e);
      checks++;
      if (d !== e) begin errors++; $display("FAIL periodic_status us=%0d: got %h want %h", us, d, e); end
      if (d[1]) begin bus_wr(32'h0, 32'h2); clears++; end
      us = us + 1;
    end
    checks++;
    if (clears != 4) begin errors++; $display("FAIL periodic_count: got %0d want 4", clears); end
    bus_rd(32'h24, d, rdy, e);
    checks++;
    if (d !== 32'd150 || d !== e) begin errors++; $display("FAIL periodic_cmp: got %0d want 150", d); end
  endtask

  task automatic test_wrap();
    logic [31:0] d, e;
    logic        rdy;
    bit          found;
    do_reset();
    us = 0;
    bus_wr(32'h34, 32'hFFFF_FFF0);
    bus_wr(32'h38, 32'hFFFF_FFFF);
    bus_wr(32'h3C, 32'h20);
    bus_wr(32'h30, 32'h3);
    us = 64'hFFFF_FFFF_FFFF_FFF0;
    found = 0;
    for (int i = 0; i < 3 * NUM_CH && !found; i++) begin
      bus_rd(32'h0, d, rdy, e);
      if (d[2]) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL wrap_fire: no pending within %0d cycles", 3 * NUM_CH); end
    us = 5;
    bus_rd(32'h34, d, rdy, e);
    checks++;
    if (d !== 32'h10 || d !== e) begin errors++; $display("FAIL wrap_cmp_lo: got %h want 10", d); end
    bus_rd(32'h38, d, rdy, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL wrap_cmp_hi: got %h want 0", d); end
    bus_wr(32'h0, 32'h4);
    for (int v = 5; v < 16; v++) begin
      us = 64'(v);
      bus_rd(32'h0, d, rdy, e);
      checks++;
      if (d[2] !== 1'b0) begin errors++; $display("FAIL wrap_early us=%0d: got %b want 0", v, d[2]); end
    end
    us = 64'h10;
    found = 0;
    for (int i = 0; i < 2 * NUM_CH && !found; i++) begin
      bus_rd(32'h0, d, rdy, e);
      if (d[2]) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL wrap_refire: no pending within %0d cycles", 2 * NUM_CH); end
    bus_rd(32'h34, d, rdy, e);
    checks++;
    if (d !== 32'h30 || d !== e) begin errors++; $display("FAIL wrap_cmp_next: got %h want 30", d); end
  endtask

  task automatic test_collision();
    logic [31:0] d, e;
    logic        rdy;
    do_reset();
    us = 0;
    bus_wr(32'h44, 200);
    bus_wr(32'h48, 0);
    bus_wr(32'h40, 32'h5);
    align(3);
    us = 300;
    bus_wr(32'h40, 32'h5);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL collide_nofire: got %b want 0", irq); end
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      step();
      checks++;
      if (irq !== 1'(k == NUM_CH) || irq !== m_irq()) begin
        errors++;
        $display("FAIL collide_refire k=%0d: got %b want %b", k, irq, 1'(k == NUM_CH));
      end
    end
    bus_wr(32'h0, 32'h8);
    align(0);
    bus_wr(32'h40, 32'h5);
    step();
    step();
    bus_wr(32'h0, 32'h8);
    bus_rd(32'h0, d, rdy, e);
    checks++;
    if (d[3] !== 1'b1 || d !== e) begin errors++; $display("FAIL w1c_vs_set: got %h want bit3=1 (%h)", d, e); end
  endtask

  task automatic test_mask_period0();
    logic [31:0] d, e;
    logic        rdy;
    do_reset();
    us = 20;
    bus_wr(32'h14, 10);
    bus_wr(32'h18, 0);
    bus_wr(32'h1C, 0);
    bus_wr(32'h10, 32'h3);
    repeat (2 * NUM_CH) step();
    bus_rd(32'h10, d, rdy, e);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL period0_ctrl: got %h want 2", d); end
    bus_wr(32'h24, 5);
    bus_wr(32'h28, 0);
    bus_wr(32'h20, 32'h1);
    repeat (2 * NUM_CH) step();
    bus_rd(32'h0, d, rdy, e);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL mask_status: got %h want 3", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq_off: got %b want 0", irq); end
    bus_wr(32'h20, 32'h4);
    checks++;
    if (irq !== 1'b1 || irq !== m_irq()) begin errors++; $display("FAIL mask_irq_on: got %b want 1", irq); end
    bus_wr(32'h20, 32'h0);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq_reoff: got %b want 0", irq); end
    bus_rd(32'h0, d, rdy, e);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL mask_keep_pending: got %h want 3", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, e;
    logic        rdy;
    do_reset();
    us = 1000;
    bus_wr(32'h1C, 3);
    bus_wr(32'h10, 32'h7);
    bus_wr(32'h24, 500);
    bus_wr(32'h2C, 7);
    bus_wr(32'h20, 32'h7);
    repeat (NUM_CH) step();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL premid_irq: got %b want 1", irq); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq: got %b want 0", irq); end
    for (int unsigned a = 0; a < 16 + 16 * NUM_CH; a += 4) begin
      bus_rd(a, d, rdy, e);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_reg@%0h: got %h want 0", a, d); end
    end
    do_reset();
    bus_wr(32'h30, 32'h5);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL ptr_edge1: got %b want 0", irq); end
    step();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL ptr_edge2: got %b want 0", irq); end
    step();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL ptr_edge3: got %b want 1", irq); end
  endtask

  task automatic test_random();
    logic [31:0] d, e, a, v;
    logic        rdy;
    int unsigned r, ch, rg;
    do_reset();
    us = 64'(32'h1000);
    for (int i = 0; i < 400; i++) begin
      us = us + 64'($urandom_range(0, 2));
      r  = $urandom_range(0, 9);
      if (r <= 3) begin
        ch = $urandom_range(0, NUM_CH - 1);
        rg = $urandom_range(0, 3);
        case (rg)
          0: v = $urandom & 32'h7;
          1: v = us[31:0] + $urandom_range(0, 40);
          2: v = us[63:32];
          default: v = $urandom_range(0, 12);
        endcase
        a = {$urandom_range(0, 255), 8'(16 + 16 * ch + 4 * rg)} & 32'hFFFF_FFFC;
        bus_wr(a, v);
      end else if (r == 4) begin
        bus_wr(32'h0, $urandom);
      end else if (r <= 6) begin
        a = {$urandom_range(0, 255), 8'($urandom_range(0, 255))};
        bus_rd(a, d, rdy, e);
        checks++;
        if (d !== e) begin errors++; $display("FAIL rand_read@%h: got %h want %h", a, d, e); end
      end else begin
        step();
      end
      checks++;
      if (irq !== m_irq()) begin errors++; $display("FAIL rand_irq i=%0d: got %b want %b", i, irq, m_irq()); end
    end
    for (int unsigned ad = 0; ad < 16 + 16 * NUM_CH; ad += 4) begin
      bus_rd(ad, d, rdy, e);
      checks++;
      if (d !== e) begin errors++; $display("FAIL rand_final@%0h: got %h want %h", ad, d, e); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    if (NUM_CH > 27) begin
      $display("FAIL num_ch: %0d exceeds 27 cycles per microsecond", NUM_CH);
      $fatal(1);
    end
    rst              = 1'b1;
    us               = '0;
    bus_if.select    = 1'b0;
    bus_if.mem_wstrb = 4'h0;
    bus_if.mem_addr  = '0;
    bus_if.mem_wdata = '0;
    m_pend = 0;
    m_cyc  = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_oneshot();
    test_periodic();
    test_wrap();
    test_collision();
    test_mask_period0();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
